// File: rtl/rename_free_list.sv
`default_nettype none
// ============================================================================
// Module   : rename_free_list
// Purpose  : Physical-register free list with multi-lane alloc/free and
//            head-pointer checkpoints for single-cycle mispredict recovery.
// Revision : 1.0 - initial release
// ============================================================================
module rename_free_list #(
    parameter  int NUM_PHYS = 64,
    parameter  int NUM_ARCH = 32,
    parameter  int ALLOC_W  = 2,
    parameter  int FREE_W   = 2,
    parameter  int NUM_CKPT = 4,
    localparam int PREG_W   = $clog2(NUM_PHYS),
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int PTR_W    = IDX_W + 1,
    localparam int CNT_W    = $clog2(ALLOC_W + 1),
    localparam int CK_W     = $clog2(NUM_CKPT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CNT_W-1:0]           alloc_cnt,
    output logic                       alloc_grant,
    output logic [ALLOC_W*PREG_W-1:0]  alloc_preg,
    input  logic [FREE_W-1:0]          free_valid,
    input  logic [FREE_W*PREG_W-1:0]   free_preg,
    output logic [PTR_W-1:0]           free_count,
    input  logic                       ckpt_save,
    output logic [CK_W-1:0]            ckpt_id,
    output logic                       ckpt_full,
    input  logic                       ckpt_release,
    input  logic                       ckpt_restore,
    input  logic [CK_W-1:0]            restore_id,
    output logic                       overflow_err
);

    localparam logic [PTR_W-1:0] c_depth    = PTR_W'(DEPTH);
    localparam logic [CK_W:0]    c_num_ckpt = (CK_W+1)'(NUM_CKPT);

    logic [PREG_W-1:0] r_ram  [DEPTH];
    logic [PTR_W-1:0]  r_slot [NUM_CKPT];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CK_W:0]     r_ck_head;
    logic [CK_W:0]     r_ck_tail;
    logic              r_overflow;

    logic [PTR_W-1:0]  w_count;
    logic [PTR_W-1:0]  w_cnt_ext;
    logic [PTR_W-1:0]  w_grant_cnt;
    logic [PTR_W-1:0]  w_head_alloc;
    logic [PTR_W-1:0]  w_room;
    logic [PTR_W-1:0]  w_acc;
    logic [FREE_W-1:0] w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx [FREE_W];
    logic              w_drop;
    logic [CK_W:0]     w_ck_count;
    logic [CK_W-1:0]   w_rst_off;
    logic              w_rst_live;
    logic              w_do_restore;
    logic              w_do_save;
    logic              w_do_ck_rel;

    assign w_count      = r_tail - r_head;
    assign free_count   = w_count;
    assign overflow_err = r_overflow;

    assign w_cnt_ext    = PTR_W'(alloc_cnt);
    assign alloc_grant  = !ckpt_restore && (w_cnt_ext <= w_count);
    assign w_grant_cnt  = alloc_grant ? w_cnt_ext : '0;
    assign w_head_alloc = r_head + w_grant_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < ALLOC_W; gi++) begin : g_alloc
            logic [IDX_W-1:0] w_rd_idx;
            assign w_rd_idx = r_head[IDX_W-1:0] + IDX_W'(gi);
            assign alloc_preg[gi*PREG_W +: PREG_W] = r_ram[w_rd_idx];
        end
    endgenerate

    assign w_ck_count   = r_ck_tail - r_ck_head;
    assign ckpt_full    = (w_ck_count == c_num_ckpt);
    assign ckpt_id      = r_ck_tail[CK_W-1:0];
    // A slot is live when its age offset from the oldest entry is within the count.
    assign w_rst_off    = restore_id - r_ck_head[CK_W-1:0];
    assign w_rst_live   = ({1'b0, w_rst_off} < w_ck_count);
    assign w_do_restore = ckpt_restore && w_rst_live;
    assign w_do_save    = ckpt_save && !ckpt_full && !ckpt_restore;
    assign w_do_ck_rel  = ckpt_release && (w_ck_count != '0) && !ckpt_restore;

    // Room left once this cycle's allocation has been taken out.
    assign w_room = c_depth - (w_count - w_grant_cnt);

    always_comb begin
        w_acc   = '0;
        w_drop  = 1'b0;
        w_wr_en = '0;
        for (int l = 0; l < FREE_W; l++) begin
            w_wr_idx[l] = r_tail[IDX_W-1:0] + w_acc[IDX_W-1:0];
            if (free_valid[l]) begin
                if (w_acc < w_room) begin
                    w_wr_en[l] = 1'b1;
                    w_acc      = w_acc + PTR_W'(1);
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ram[i] <= PREG_W'(NUM_ARCH + i);
            end
            for (int k = 0; k < NUM_CKPT; k++) begin
                r_slot[k] <= '0;
            end
            r_head     <= '0;
            r_tail     <= c_depth;
            r_ck_head  <= '0;
            r_ck_tail  <= '0;
            r_overflow <= 1'b0;
        end else begin
            for (int l = 0; l < FREE_W; l++) begin
                if (w_wr_en[l]) begin
                    r_ram[w_wr_idx[l]] <= free_preg[l*PREG_W +: PREG_W];
                end
            end
            r_tail <= r_tail + w_acc;

            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            if (w_do_restore) begin
                r_head <= r_slot[restore_id];
            end else begin
                r_head <= w_head_alloc;
            end

            if (w_do_save) begin
                r_slot[r_ck_tail[CK_W-1:0]] <= w_head_alloc;
            end

            if (w_do_restore) begin
                r_ck_tail <= r_ck_head + {1'b0, w_rst_off} + (CK_W+1)'(1);
            end else if (w_do_save) begin
                r_ck_tail <= r_ck_tail + (CK_W+1)'(1);
            end

            if (w_do_ck_rel) begin
                r_ck_head <= r_ck_head + (CK_W+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rename_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_free_list
// Purpose  : Directed self-checking bench for rename_free_list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rename_free_list;

    logic        clk;
    logic        rst;
    logic [1:0]  alloc_cnt;
    logic        alloc_grant;
    logic [11:0] alloc_preg;
    logic [1:0]  free_valid;
    logic [11:0] free_preg;
    logic [5:0]  free_count;
    logic        ckpt_save;
    logic [1:0]  ckpt_id;
    logic        ckpt_full;
    logic        ckpt_release;
    logic        ckpt_restore;
    logic [1:0]  restore_id;
    logic        overflow_err;

    int n_vec  = 0;
    int n_miss = 0;

    rename_free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_cnt    (alloc_cnt),
        .alloc_grant  (alloc_grant),
        .alloc_preg   (alloc_preg),
        .free_valid   (free_valid),
        .free_preg    (free_preg),
        .free_count   (free_count),
        .ckpt_save    (ckpt_save),
        .ckpt_id      (ckpt_id),
        .ckpt_full    (ckpt_full),
        .ckpt_release (ckpt_release),
        .ckpt_restore (ckpt_restore),
        .restore_id   (restore_id),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_cnt    = 2'd0;
        free_valid   = 2'b00;
        free_preg    = '0;
        ckpt_save    = 1'b0;
        ckpt_release = 1'b0;
        ckpt_restore = 1'b0;
        restore_id   = 2'd0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        do_reset();

        // Reset state
        chk("rst_free_count", 32'(free_count), 32);
        chk("rst_ckpt_full", 32'(ckpt_full), 0);
        chk("rst_overflow", 32'(overflow_err), 0);
        chk("rst_ckpt_id", 32'(ckpt_id), 0);
        chk("rst_grant_cnt0", 32'(alloc_grant), 1);

        // Three double allocations
        for (int k = 0; k < 3; k++) begin
            alloc_cnt = 2'd2;
            #1;
            chk("alloc2_grant", 32'(alloc_grant), 1);
            chk("alloc2_preg0", 32'(alloc_preg[5:0]), 32 + 2*k);
            chk("alloc2_preg1", 32'(alloc_preg[11:6]), 33 + 2*k);
            tick();
        end
        idle();
        #1;
        chk("alloc2_free_count", 32'(free_count), 26);

        // Single alloc then drain to one remaining
        alloc_cnt = 2'd1;
        #1;
        chk("alloc1_preg0", 32'(alloc_preg[5:0]), 38);
        tick();
        for (int k = 0; k < 12; k++) begin
            alloc_cnt = 2'd2;
            #1;
            chk("drain_preg0", 32'(alloc_preg[5:0]), 39 + 2*k);
            tick();
        end
        idle();
        #1;
        chk("drain_free_count", 32'(free_count), 1);

        alloc_cnt = 2'd2;
        #1;
        chk("over_req_grant", 32'(alloc_grant), 0);
        tick();
        chk("over_req_free_count", 32'(free_count), 1);
        chk("over_req_head", 32'(alloc_preg[5:0]), 63);
        alloc_cnt = 2'd1;
        #1;
        chk("last_grant", 32'(alloc_grant), 1);
        chk("last_preg", 32'(alloc_preg[5:0]), 63);
        tick();
        idle();
        #1;
        chk("empty_free_count", 32'(free_count), 0);

        // Release from empty on sparse lane 1; same-cycle alloc refused
        alloc_cnt  = 2'd1;
        free_valid = 2'b10;
        free_preg  = {6'd5, 6'd9};
        #1;
        chk("same_cycle_grant", 32'(alloc_grant), 0);
        tick();
        idle();
        #1;
        chk("freed_count", 32'(free_count), 1);
        alloc_cnt = 2'd1;
        #1;
        chk("freed_grant", 32'(alloc_grant), 1);
        chk("freed_preg", 32'(alloc_preg[5:0]), 5);
        tick();
        idle();
        #1;
        chk("freed_realloc_count", 32'(free_count), 0);

        // Checkpoint save and restore
        do_reset();
        alloc_cnt = 2'd2;
        tick();
        tick();
        alloc_cnt = 2'd1;
        ckpt_save = 1'b1;
        #1;
        chk("save_ckpt_id", 32'(ckpt_id), 0);
        chk("save_preg", 32'(alloc_preg[5:0]), 36);
        tick();
        ckpt_save = 1'b0;
        alloc_cnt = 2'd2;
        #1;
        chk("post_save_preg", 32'(alloc_preg[5:0]), 37);
        tick();
        tick();
        alloc_cnt    = 2'd2;
        ckpt_restore = 1'b1;
        restore_id   = 2'd0;
        #1;
        chk("restore_grant", 32'(alloc_grant), 0);
        tick();
        idle();
        #1;
        chk("restore_preg", 32'(alloc_preg[5:0]), 37);
        chk("restore_free_count", 32'(free_count), 27);
        chk("restore_ckpt_id", 32'(ckpt_id), 1);
        chk("restore_ckpt_full", 32'(ckpt_full), 0);

        // Fill the ring
        for (int k = 1; k < 4; k++) begin
            ckpt_save = 1'b1;
            #1;
            chk("fill_ckpt_id", 32'(ckpt_id), k);
            tick();
        end
        idle();
        #1;
        chk("fill_full", 32'(ckpt_full), 1);
        ckpt_save = 1'b1;
        tick();
        idle();
        #1;
        chk("fifth_save_full", 32'(ckpt_full), 1);
        chk("fifth_save_id", 32'(ckpt_id), 0);

        ckpt_release = 1'b1;
        tick();
        idle();
        #1;
        chk("release_full", 32'(ckpt_full), 0);

        // Restore of slot 3 with a concurrent release: release must be ignored
        ckpt_restore = 1'b1;
        ckpt_release = 1'b1;
        restore_id   = 2'd3;
        tick();
        idle();
        #1;
        chk("rst_rel_full", 32'(ckpt_full), 0);
        chk("rst_rel_ckpt_id", 32'(ckpt_id), 0);
        chk("rst_rel_free_count", 32'(free_count), 27);
        ckpt_save = 1'b1;
        tick();
        idle();
        #1;
        chk("rst_rel_refill_full", 32'(ckpt_full), 1);
        chk("rst_rel_refill_id", 32'(ckpt_id), 1);

        // Overflow: one lane fits after the same-cycle allocation, one dropped
        do_reset();
        alloc_cnt  = 2'd1;
        free_valid = 2'b11;
        free_preg  = {6'd8, 6'd7};
        #1;
        chk("ovf_grant", 32'(alloc_grant), 1);
        chk("ovf_preg", 32'(alloc_preg[5:0]), 32);
        tick();
        idle();
        #1;
        chk("ovf_flag", 32'(overflow_err), 1);
        chk("ovf_free_count", 32'(free_count), 32);
        alloc_cnt = 2'd2;
        tick();
        idle();
        #1;
        chk("ovf_sticky", 32'(overflow_err), 1);
        chk("ovf_sticky_count", 32'(free_count), 30);
        do_reset();
        chk("ovf_cleared", 32'(overflow_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
